stdp_update_scheduler: RTL and testbench
========================================

// Module: stdp_update_scheduler
// PURPOSE
// - Sequences the STDP weight-update datapath for one physical neuron core.
// - Tracks presynaptic spike age and queues postsynaptic spike events.
// - Round-robin arbitrates between pending post neurons.
// - For each granted neuron, walks all N_PRE synapses: read weight, look up dw, write clamped weight.
// - Sits between the spike fabric, the shared weight memory and the combinational STDP LUT.
// PARAMETERS
// - N_PRE   8   presynaptic inputs per neuron
// - N_POST  8   postsynaptic neurons sharing the updater
// - AGE_W   8   spike-age counter width (ticks)
// - W_W     8   unsigned weight width
// - DW_W    8   signed LUT delta-weight width
// - WINDOW  20  max age (ticks) that causes an update; older is skipped
// PORTS
// - clk          in   1                          system clock
// - rst          in   1                          synchronous, active-high reset
// - kill         in   1                          synchronous abort of all update activity
// - time_tick    in   1                          STDP time-step strobe
// - pre_spike    in   N_PRE                      presynaptic spike pulses
// - post_spike   in   N_POST                     postsynaptic spike pulses
// - wmem_re      out  1                          weight read enable
// - wmem_we      out  1                          weight write enable
// - wmem_addr    out  clog2(N_POST)+clog2(N_PRE) {post_idx, pre_idx}
// - wmem_wdata   out  W_W                        updated weight
// - wmem_rdata   in   W_W                        read data, valid 1 cycle after wmem_re
// - lut_delta    out  AGE_W                      age sent to STDP LUT
// - lut_dw       in   DW_W                       signed dw, combinational from lut_delta
// - o_wait       out  1                          high whenever FSM is not IDLE
// - upd_done     out  1                          1-cycle pulse when a neuron's sweep ends
// BEHAVIOUR
// - Reset: all outputs 0; ages 0; valid bits 0; pending 0; RR pointer 0; FSM IDLE.
// - Age tracking, per pre i:
//   - pre_spike[i] sets age=0 and valid=1.
//   - Otherwise time_tick increments age, saturating at 2^AGE_W-1.
//   - pre_spike wins over a simultaneous tick.
// - Pending: post_spike[j] sets pend[j]; repeats while pending merge into one request.
//   - A spike on the neuron in service re-sets pend[j], so it is serviced again later.
// - Grant: fixed-priority search starting at RR pointer. Pointer moves to grant+1 (mod N_POST).
// - FSM:
//   - IDLE -> GRANT when any pend is set (GRANT clears pend[g] and latches g).
//   - GRANT -> RD with pre_idx=0.
//   - RD: if !valid[p] or age[p]>WINDOW -> SKIP. Else assert wmem_re and latch age into lut_delta, -> CALC.
//   - CALC: wmem_rdata valid; register wdata = clamp(rdata + sext(lut_dw), 0, 2^W_W-1) -> WR.
//   - WR: assert wmem_we with wmem_wdata -> NEXT.
//   - SKIP -> NEXT (no memory access).
//   - NEXT: if p==N_PRE-1, pulse upd_done and go IDLE; else p++ and go RD.
// - Latency: 2 + 4*N_PRE cycles worst case per neuron (all synapses active), 2 + 2*N_PRE all skipped.
// - Age is sampled in RD; pre spikes during the sweep affect later synapses only.
// - kill:
//   - Next cycle FSM is IDLE; pend cleared; re/we deasserted in the kill cycle (no partial write).
//   - Ages, valid bits and RR pointer are kept.
//   - rst and kill in the same cycle behave as rst.
// - Arithmetic: add done at W_W+2 signed width before clamping. dw=-128 on weight 5 gives 0; +100 on 200 gives 255.
// STRUCTURE
// - stdp_pkg: FSM state enum (IDLE,GRANT,RD,CALC,WR,SKIP,NEXT), width localparams, WINDOW default.
// - Sub-module stdp_rr_arbiter: N_POST request vector in, one-hot grant + index out, pointer update on accept.
// - Age counters, FSM and clamp stay in this module.
// TESTING
// - Reset then idle 50 ticks, no spikes -> o_wait=0, no wmem_re/we, upd_done never pulses.
// - pre0 spike, 3 ticks, post2 spike; LUT dw=+4, rdata=100
//   -> addr {2,0} read, lut_delta=3, write 104; other synapses skipped; upd_done after 2+4+2*7 cycles.
// - post1 and post5 spike in the same cycle, RR ptr=3 -> post5 serviced first, then post1; ptr ends at 2.
// - pre3 age 25 > WINDOW -> SKIP, no access. Clamp cases: rdata=250 dw=+20 -> 255; rdata=3 dw=-9 -> 0.
// - kill asserted during CALC of synapse 4 -> no wmem_we that sweep, o_wait=0 next cycle, pend cleared.
// - post2 re-spikes mid-sweep of post2 -> second full sweep follows immediately after upd_done.

Source files
------------

// File: rtl/stdp_pkg.sv
// Shared types and default sizing for the STDP update scheduler.
// The FSM state set is fixed; sizes below are defaults for the top's parameters.
package stdp_pkg;

  localparam int N_PRE_DEF  = 8;
  localparam int N_POST_DEF = 8;
  localparam int AGE_W_DEF  = 8;
  localparam int W_W_DEF    = 8;
  localparam int DW_W_DEF   = 8;
  localparam int WINDOW_DEF = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    RD    = 3'd2,
    CALC  = 3'd3,
    WR    = 3'd4,
    SKIP  = 3'd5,
    NEXT  = 3'd6
  } state_t;

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin arbiter: fixed-priority search starting at the pointer,
// pointer moves to grant+1 when the grant is accepted. N must be a power of 2.
module stdp_rr_arbiter #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any        = 1'b1;
        gnt_idx    = cand;
        gnt[cand]  = 1'b1;
      end else begin
        any = any;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/stdp_update_scheduler.sv
// STDP weight-update sequencer: tracks pre-spike ages, queues post spikes,
// and sweeps every synapse of a granted neuron through read / LUT / clamped write.
module stdp_update_scheduler
  import stdp_pkg::*;
#(
  parameter int N_PRE  = N_PRE_DEF,
  parameter int N_POST = N_POST_DEF,
  parameter int AGE_W  = AGE_W_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int DW_W   = DW_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     kill,
  input  logic                                     time_tick,
  input  logic [N_PRE-1:0]                         pre_spike,
  input  logic [N_POST-1:0]                        post_spike,
  output logic                                     wmem_re,
  output logic                                     wmem_we,
  output logic [$clog2(N_POST)+$clog2(N_PRE)-1:0]  wmem_addr,
  output logic [W_W-1:0]                           wmem_wdata,
  input  logic [W_W-1:0]                           wmem_rdata,
  output logic [AGE_W-1:0]                         lut_delta,
  input  logic [DW_W-1:0]                          lut_dw,
  output logic                                     o_wait,
  output logic                                     upd_done
);

  localparam int PW = $clog2(N_PRE);
  localparam int QW = $clog2(N_POST);
  localparam int SW = W_W + 2;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] WIN     = AGE_W'(WINDOW);

  state_t              state, next_state;
  logic [AGE_W-1:0]    age [N_PRE];
  logic [N_PRE-1:0]    valid;
  logic [N_POST-1:0]   pend, pend_clr;
  logic [N_POST-1:0]   gnt;
  logic [QW-1:0]       gnt_idx, post_idx;
  logic [PW-1:0]       pre_idx;
  logic [W_W-1:0]      wdata;
  logic                any_req, accept, syn_active, last_pre;
  logic signed [SW-1:0] sum;
  logic [W_W-1:0]      clamped;

  assign accept     = (state == IDLE) && !kill;
  assign syn_active = valid[pre_idx] && (age[pre_idx] <= WIN);
  assign last_pre   = (pre_idx == PW'(N_PRE - 1));

  stdp_rr_arbiter #(.N(N_POST)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (pend),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) age[i] <= '0;
      valid <= '0;
    end else begin
      for (int i = 0; i < N_PRE; i++) begin
        if (pre_spike[i]) begin
          age[i]   <= '0;
          valid[i] <= 1'b1;
        end else if (time_tick && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

  // A new spike on the neuron being granted wins over the grant's clear.
  always_comb begin
    if (accept && any_req) pend_clr = gnt;
    else                   pend_clr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) pend <= '0;
    else             pend <= (pend & ~pend_clr) | post_spike;
  end

  // Weight update computed wide and signed so both rails can be detected.
  always_comb begin
    sum = $signed({2'b00, wmem_rdata}) + SW'($signed(lut_dw));
    if (sum[SW-1])             clamped = '0;
    else if (|sum[SW-2:W_W])   clamped = '1;
    else                       clamped = sum[W_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = any_req ? GRANT : IDLE;
      GRANT: next_state = RD;
      RD:    next_state = syn_active ? CALC : SKIP;
      CALC:  next_state = WR;
      WR:    next_state = NEXT;
      SKIP:  next_state = last_pre ? IDLE : RD;
      NEXT:  next_state = last_pre ? IDLE : RD;
      default: next_state = IDLE;
    endcase
    if (kill) next_state = IDLE;
    else      next_state = next_state;
  end

  // SKIP folds in the advance step so a skipped synapse costs two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_idx  <= '0;
      pre_idx   <= '0;
      lut_delta <= '0;
      wdata     <= '0;
    end else begin
      if (accept && any_req) post_idx <= gnt_idx;
      if (state == GRANT) begin
        pre_idx <= '0;
      end else if (((state == NEXT) || (state == SKIP)) && !last_pre) begin
        pre_idx <= pre_idx + PW'(1);
      end
      if ((state == RD) && syn_active) lut_delta <= age[pre_idx];
      if (state == CALC) wdata <= clamped;
    end
  end

  always_comb begin
    wmem_re    = (state == RD) && syn_active && !kill;
    wmem_we    = (state == WR) && !kill;
    upd_done   = ((state == NEXT) || (state == SKIP)) && last_pre && !kill;
    o_wait     = (state != IDLE);
    wmem_addr  = {post_idx, pre_idx};
    wmem_wdata = wdata;
  end

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler with a behavioural weight memory
// and a table-driven STDP LUT indexed by lut_delta.
module tb_stdp_update_scheduler;

  logic       clk = 1'b0;
  logic       rst, kill, time_tick;
  logic [7:0] pre_spike, post_spike;
  logic       wmem_re, wmem_we, o_wait, upd_done;
  logic [5:0] wmem_addr;
  logic [7:0] wmem_wdata, wmem_rdata, lut_delta, lut_dw;

  logic [7:0] mem [64];
  logic [7:0] lut_tab [256];
  logic       ld_en;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;

  int vectors = 0;
  int fails   = 0;
  int re_cnt = 0, we_cnt = 0, done_cnt = 0, wait_cnt = 0, rd3_cnt = 0;
  logic [5:0] last_waddr = 6'd0;
  logic [7:0] last_wdata = 8'd0, lut_at_we = 8'd0;
  logic [2:0] done_log [64];
  int n, lat, b_re, b_we, b_done, b_wait, b_rd3;

  always #5 clk = ~clk;

  stdp_update_scheduler dut (
    .clk(clk), .rst(rst), .kill(kill), .time_tick(time_tick),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .wmem_re(wmem_re), .wmem_we(wmem_we), .wmem_addr(wmem_addr),
    .wmem_wdata(wmem_wdata), .wmem_rdata(wmem_rdata),
    .lut_delta(lut_delta), .lut_dw(lut_dw),
    .o_wait(o_wait), .upd_done(upd_done)
  );

  assign lut_dw = lut_tab[lut_delta];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
      wmem_rdata <= 8'd0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wmem_re) wmem_rdata <= mem[wmem_addr];
      if (wmem_we) mem[wmem_addr] <= wmem_wdata;
    end
  end

  always @(negedge clk) begin
    if (wmem_re) begin
      re_cnt <= re_cnt + 1;
      if (wmem_addr[2:0] == 3'd3) rd3_cnt <= rd3_cnt + 1;
    end
    if (wmem_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= wmem_addr;
      last_wdata <= wmem_wdata;
      lut_at_we  <= lut_delta;
    end
    if (upd_done) begin
      done_log[done_cnt[5:0]] <= wmem_addr[5:3];
      done_cnt <= done_cnt + 1;
    end
    if (o_wait) wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic pulse_pre(input int i);
    pre_spike = 8'd0;
    pre_spike[i] = 1'b1;
    cyc();
    pre_spike = 8'd0;
  endtask

  task automatic pulse_post(input logic [7:0] m);
    post_spike = m;
    cyc();
    post_spike = 8'd0;
  endtask

  task automatic ticks(input int k);
    time_tick = 1'b1;
    repeat (k) cyc();
    time_tick = 1'b0;
  endtask

  // Counts edges until upd_done is visible, bounded.
  task automatic wait_done(output int e);
    e = 0;
    do begin cyc(); e++; end while (!upd_done && e < 200);
    chk("done_seen", {31'd0, upd_done}, 32'd1);
  endtask

  task automatic snap();
    b_re = re_cnt; b_we = we_cnt; b_done = done_cnt; b_wait = wait_cnt; b_rd3 = rd3_cnt;
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; time_tick = 1'b0;
    pre_spike = 8'd0; post_spike = 8'd0;
    ld_en = 1'b0; ld_addr = 6'd0; ld_data = 8'd0;
    for (int i = 0; i < 256; i++) lut_tab[i] = 8'd0;
    repeat (3) cyc();
    rst = 1'b0;

    chk("rst_wait", {31'd0, o_wait}, 32'd0);
    chk("rst_re",   {31'd0, wmem_re}, 32'd0);
    chk("rst_we",   {31'd0, wmem_we}, 32'd0);
    chk("rst_done", {31'd0, upd_done}, 32'd0);
    chk("rst_addr", {26'd0, wmem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, wmem_wdata}, 32'd0);
    chk("rst_delta", {24'd0, lut_delta}, 32'd0);

    // Idle: 50 ticks without spikes.
    snap();
    ticks(50);
    chk("idle_wait", wait_cnt - b_wait, 32'd0);
    chk("idle_re",   re_cnt - b_re, 32'd0);
    chk("idle_we",   we_cnt - b_we, 32'd0);
    chk("idle_done", done_cnt - b_done, 32'd0);

    // Single active synapse: pre0 age 3, dw +4 on 100.
    lut_tab[3] = 8'd4;
    load(6'd16, 8'd100);
    snap();
    pulse_pre(0);
    ticks(3);
    pulse_post(8'h04);
    wait_done(n);
    lat = 1 + n;
    chk("t2_latency", lat, 32'd20);
    chk("t2_re",      re_cnt - b_re, 32'd1);
    chk("t2_we",      we_cnt - b_we, 32'd1);
    chk("t2_waddr",   {26'd0, last_waddr}, 32'd16);
    chk("t2_wdata",   {24'd0, last_wdata}, 32'd104);
    chk("t2_delta",   {24'd0, lut_at_we}, 32'd3);
    chk("t2_mem",     {24'd0, mem[16]}, 32'd104);
    cyc();
    chk("t2_done_cnt", done_cnt - b_done, 32'd1);

    // Round robin: pointer is 3, so post5 before post1; pointer then 2.
    snap();
    pulse_post(8'h22);
    wait_done(n);
    wait_done(n);
    cyc();
    chk("t3_first",  {29'd0, done_log[b_done[5:0]]}, 32'd5);
    chk("t3_second", {29'd0, done_log[b_done[5:0] + 6'd1]}, 32'd1);
    snap();
    pulse_post(8'h06);
    wait_done(n);
    wait_done(n);
    cyc();
    chk("t3_ptr_first",  {29'd0, done_log[b_done[5:0]]}, 32'd2);
    chk("t3_ptr_second", {29'd0, done_log[b_done[5:0] + 6'd1]}, 32'd1);
    chk("t3_we", we_cnt - b_we, 32'd2);

    // Window and clamp: ages pre0 28, pre1 2, pre2 0, pre3 25, pre5 20, pre6 21.
    lut_tab[2]  = 8'd20;
    lut_tab[0]  = 8'hF7;
    lut_tab[20] = 8'd1;
    load(6'd33, 8'd250);
    load(6'd34, 8'd3);
    load(6'd35, 8'd77);
    load(6'd37, 8'd10);
    load(6'd38, 8'd50);
    pulse_pre(3);
    ticks(4);
    pulse_pre(6);
    ticks(1);
    pulse_pre(5);
    ticks(18);
    pulse_pre(1);
    ticks(2);
    pulse_pre(2);
    snap();
    pulse_post(8'h10);
    wait_done(n);
    lat = 1 + n;
    cyc();
    chk("t4_latency", lat, 32'd24);
    chk("t4_re",      re_cnt - b_re, 32'd3);
    chk("t4_we",      we_cnt - b_we, 32'd3);
    chk("t4_rd_pre3", rd3_cnt - b_rd3, 32'd0);
    chk("t4_clamp_hi", {24'd0, mem[33]}, 32'd255);
    chk("t4_clamp_lo", {24'd0, mem[34]}, 32'd0);
    chk("t4_skip_mem", {24'd0, mem[35]}, 32'd77);
    chk("t4_window_edge", {24'd0, mem[37]}, 32'd11);
    chk("t4_past_window", {24'd0, mem[38]}, 32'd50);

    // Kill during CALC of synapse 4 of post3, with post6 pending.
    load(6'd28, 8'd60);
    pulse_pre(4);
    snap();
    pulse_post(8'h08);
    pulse_post(8'h40);
    for (int i = 0; i < 100 && !(wmem_re && wmem_addr == 6'd28); i++) cyc();
    chk("t5_reach_rd4", {31'd0, wmem_re && (wmem_addr == 6'd28)}, 32'd1);
    cyc();
    kill = 1'b1;
    cyc();
    kill = 1'b0;
    chk("t5_wait_after_kill", {31'd0, o_wait}, 32'd0);
    snap();
    repeat (10) cyc();
    chk("t5_pend_cleared", wait_cnt - b_wait, 32'd0);
    chk("t5_no_done",      done_cnt - b_done, 32'd0);
    chk("t5_mem_syn4",     {24'd0, mem[28]}, 32'd60);
    chk("t5_mem_syn1",     {24'd0, mem[25]}, 32'd20);

    // Kill in the WR cycle suppresses the write immediately.
    pulse_post(8'h08);
    for (int i = 0; i < 100 && !(wmem_re && wmem_addr == 6'd25); i++) cyc();
    cyc();
    cyc();
    chk("t5b_wr_reached", {31'd0, wmem_we}, 32'd1);
    kill = 1'b1;
    #1;
    chk("t5b_we_gated", {31'd0, wmem_we}, 32'd0);
    cyc();
    kill = 1'b0;
    chk("t5b_idle", {31'd0, o_wait}, 32'd0);
    cyc();
    chk("t5b_mem_kept", {24'd0, mem[25]}, 32'd20);

    // Re-spike of post2 mid-sweep: second sweep follows straight away.
    snap();
    pulse_post(8'h04);
    repeat (5) cyc();
    pulse_post(8'h04);
    wait_done(n);
    lat = 7 + n;
    chk("t6_first_latency", lat, 32'd26);
    wait_done(n);
    chk("t6_second_latency", n, 32'd26);
    cyc();
    chk("t6_sweeps", done_cnt - b_done, 32'd2);
    chk("t6_post_a", {29'd0, done_log[b_done[5:0]]}, 32'd2);
    chk("t6_post_b", {29'd0, done_log[b_done[5:0] + 6'd1]}, 32'd2);
    repeat (3) cyc();
    chk("t6_idle", {31'd0, o_wait}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
